pio_bank: RTL and testbench

PIO_BANK -- requirements
Module: pio_bank

---
 rtl/pio_bank_pkg.sv | 20 ++
 rtl/pio_debounce.sv | 97 +++++++++
 rtl/pio_bank.sv | 143 ++++++++++++++
 tb/tb_pio_bank.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_bank_pkg.sv
// pio_bank_pkg: shared definitions for the PIO bank.
//   - pio_reg_e   : per-channel register offsets (low two address bits)
//   - EDGE_*      : edge-capture sense selectors for the EDGE_MODE parameter
//   - BUS_W       : width of the memory-mapped data bus
package pio_bank_pkg;

    localparam int BUS_W = 32;

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,   // R: debounced input word, W: load output register
        REG_MASK = 2'd1,   // RW: interrupt mask
        REG_EDGE = 2'd2,   // R: captured edges, W: write-1-to-clear
        REG_SET  = 2'd3    // R: output register, W: OR into output register
    } pio_reg_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

endpackage

// File: rtl/pio_debounce.sv
// pio_debounce: input conditioning for one PIO channel.
//   2-FF synchronizer -> debounce counter -> stable word -> edge detect.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   din          : raw asynchronous input word
//   stable_o     : debounced word (what DATA reads)
//   edge_o       : one-cycle edge pulses per bit, selected by EDGE_MODE
module pio_debounce
    import pio_bank_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEB_CYCLES = 16,
    parameter int EDGE_MODE  = EDGE_RISE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] stable_o,
    output logic [DATA_W-1:0] edge_o
);

    logic [DATA_W-1:0] sync1_q;
    logic [DATA_W-1:0] sync2_q;
    logic [DATA_W-1:0] stable;
    logic [DATA_W-1:0] stable_dly_q;
    logic [DATA_W-1:0] rise;
    logic [DATA_W-1:0] fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_dly_q <= '0;
        end else begin
            sync1_q      <= din;
            sync2_q      <= sync1_q;
            stable_dly_q <= stable;
        end
    end

    generate
        if (DEB_CYCLES == 0) begin : g_bypass
            assign stable = sync2_q;
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEB_CYCLES + 1);

            logic [CNT_W-1:0]  cnt_q;
            logic [CNT_W-1:0]  cnt_d;
            logic [DATA_W-1:0] stable_q;
            logic [DATA_W-1:0] stable_d;

            // sync1_q is the candidate for the next cycle, so a mismatch with
            // sync2_q means the candidate changes at this edge: restart.
            // cnt_q counts edges the candidate has already been held; the
            // DEB_CYCLES-th unchanged edge commits it to the stable word.
            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                if (sync1_q != sync2_q) begin
                    cnt_d = '0;
                end else begin
                    if (cnt_q < CNT_W'(DEB_CYCLES)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q >= CNT_W'(DEB_CYCLES - 1)) begin
                        stable_d = sync2_q;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q    <= '0;
                    stable_q <= '0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign stable = stable_q;
        end
    endgenerate

    always_comb begin
        rise = stable & ~stable_dly_q;
        fall = ~stable & stable_dly_q;
        case (EDGE_MODE)
            EDGE_FALL: edge_o = fall;
            EDGE_BOTH: edge_o = rise | fall;
            default:   edge_o = rise;
        endcase
    end

    assign stable_o = stable;

endmodule

// File: rtl/pio_bank.sv
// pio_bank: NUM_CH-channel memory-mapped PIO block.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   avs_address        : {channel, register}; register in the low two bits
//   avs_read/avs_write : single-cycle access strobes, no wait states
//   avs_writedata      : write data; bits above DATA_W ignored
//   avs_readdata       : registered read data, zero above DATA_W
//   avs_readdatavalid  : pulses exactly one cycle after each avs_read
//   pio_in             : asynchronous inputs, channel c at [c*DATA_W +: DATA_W]
//   pio_out            : registered outputs, same packing
//   irq                : registered level interrupt, any (EDGE_CAP & IRQ_MASK)
//
// Bus handshake: there is no ready/waitrequest; an access is accepted on the
// edge where its strobe is high. A read produces avs_readdatavalid=1 with its
// data on the following cycle only; avs_readdata holds otherwise. A read in
// the same cycle as a write returns the value from before that write.
module pio_bank
    import pio_bank_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int DEB_CYCLES = 16,
    parameter int EDGE_MODE  = EDGE_RISE
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [$clog2(NUM_CH)+1:0]  avs_address,
    input  logic                       avs_read,
    input  logic                       avs_write,
    input  logic [BUS_W-1:0]           avs_writedata,
    output logic [BUS_W-1:0]           avs_readdata,
    output logic                       avs_readdatavalid,
    input  logic [NUM_CH*DATA_W-1:0]   pio_in,
    output logic [NUM_CH*DATA_W-1:0]   pio_out,
    output logic                       irq
);

    localparam int ADDR_W = $clog2(NUM_CH) + 2;

    typedef logic [NUM_CH-1:0][DATA_W-1:0] bank_t;

    bank_t out_q, out_d;
    bank_t mask_q, mask_d;
    bank_t edge_q, edge_d;
    bank_t stable_w;
    bank_t edge_w;

    logic             irq_q, irq_d;
    logic [BUS_W-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    logic [ADDR_W-1:0] ch_addr;
    pio_reg_e          reg_sel;
    logic [DATA_W-1:0] wdata;
    logic              unused_wdata;

    // Channel index keeps full address width so indices >= NUM_CH simply
    // match no channel: reads return 0, writes are dropped.
    assign ch_addr      = avs_address >> 2;
    assign reg_sel      = pio_reg_e'(avs_address[1:0]);
    assign wdata        = avs_writedata[DATA_W-1:0];
    assign unused_wdata = ^avs_writedata;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pio_debounce #(
            .DATA_W     (DATA_W),
            .DEB_CYCLES (DEB_CYCLES),
            .EDGE_MODE  (EDGE_MODE)
        ) u_deb (
            .clk      (clk),
            .reset_n  (reset_n),
            .din      (pio_in[g*DATA_W +: DATA_W]),
            .stable_o (stable_w[g]),
            .edge_o   (edge_w[g])
        );
    end

    // Register writes. The capture OR is applied after the W1C mask so a
    // fresh edge in the clearing cycle survives.
    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        edge_d = edge_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (avs_write && (ch_addr == ADDR_W'(c))) begin
                case (reg_sel)
                    REG_DATA: out_d[c]  = wdata;
                    REG_MASK: mask_d[c] = wdata;
                    REG_EDGE: edge_d[c] = edge_q[c] & ~wdata;
                    REG_SET:  out_d[c]  = out_q[c] | wdata;
                    default:  ;
                endcase
            end
        end
        edge_d = edge_d | edge_w;
    end

    assign irq_d = |(edge_q & mask_q);

    // Read mux works on current register values, giving read-before-write.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = avs_read;
        if (avs_read) begin
            rdata_d = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_addr == ADDR_W'(c)) begin
                    case (reg_sel)
                        REG_DATA: rdata_d = BUS_W'(stable_w[c]);
                        REG_MASK: rdata_d = BUS_W'(mask_q[c]);
                        REG_EDGE: rdata_d = BUS_W'(edge_q[c]);
                        REG_SET:  rdata_d = BUS_W'(out_q[c]);
                        default:  rdata_d = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q    <= '0;
            mask_q   <= '0;
            edge_q   <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign pio_out           = out_q;
    assign irq               = irq_q;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_pio_bank.sv
`timescale 1ns/1ps
module tb_pio_bank;
    import pio_bank_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata, avs_readdata;
    logic        avs_readdatavalid;
    logic [31:0] pio_in, pio_out;
    logic        irq;

    // second instance with 5 channels so that index 5 is addressable
    logic [4:0]  b_address;
    logic        b_read, b_write;
    logic [31:0] b_writedata, b_readdata;
    logic        b_rvalid;
    logic [39:0] b_pio_in, b_pio_out;
    logic        b_irq;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] exp_b_q[$];
    string       name_b_q[$];
    logic [31:0] mon_e, mon_b_e;
    string       mon_nm, mon_b_nm;

    always #5 clk = ~clk;

    pio_bank #(.NUM_CH(4), .DATA_W(8), .DEB_CYCLES(4), .EDGE_MODE(EDGE_RISE)) dut (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid), .pio_in(pio_in), .pio_out(pio_out), .irq(irq)
    );

    pio_bank #(.NUM_CH(5), .DATA_W(8), .DEB_CYCLES(4), .EDGE_MODE(EDGE_RISE)) dut_b (
        .clk(clk), .reset_n(reset_n), .avs_address(b_address), .avs_read(b_read),
        .avs_write(b_write), .avs_writedata(b_writedata), .avs_readdata(b_readdata),
        .avs_readdatavalid(b_rvalid), .pio_in(b_pio_in), .pio_out(b_pio_out), .irq(b_irq)
    );

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop one expectation per readdatavalid pulse.
    always @(negedge clk) begin
        if (reset_n && avs_readdatavalid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rdvalid: got readdatavalid=1 with data 0x%0h, expected no read", avs_readdata);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_nm = name_q.pop_front();
                check(mon_nm, 64'(avs_readdata), 64'(mon_e));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && b_rvalid) begin
            if (exp_b_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rdvalid_b: got readdatavalid=1 with data 0x%0h, expected no read", b_readdata);
            end else begin
                mon_b_e  = exp_b_q.pop_front();
                mon_b_nm = name_b_q.pop_front();
                check(mon_b_nm, 64'(b_readdata), 64'(mon_b_e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int ch, input pio_reg_e r, input logic [31:0] d);
        avs_address   = 4'(ch * 4 + int'(r));
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input int ch, input pio_reg_e r, input logic [31:0] e, input string nm);
        avs_address = 4'(ch * 4 + int'(r));
        avs_read    = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        tick();
        avs_read    = 1'b0;
    endtask

    task automatic bus_rw(input int ch, input pio_reg_e r, input logic [31:0] d,
                          input logic [31:0] e, input string nm);
        avs_address   = 4'(ch * 4 + int'(r));
        avs_writedata = d;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        tick();
        avs_write     = 1'b0;
        avs_read      = 1'b0;
    endtask

    task automatic b_bus_write(input int ch, input pio_reg_e r, input logic [31:0] d);
        b_address   = 5'(ch * 4 + int'(r));
        b_writedata = d;
        b_write     = 1'b1;
        tick();
        b_write     = 1'b0;
    endtask

    task automatic b_bus_read(input int ch, input pio_reg_e r, input logic [31:0] e, input string nm);
        b_address = 5'(ch * 4 + int'(r));
        b_read    = 1'b1;
        exp_b_q.push_back(e);
        name_b_q.push_back(nm);
        tick();
        b_read    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (exp_q.size() != 0 || exp_b_q.size() != 0); i++) tick();
        check("drain_pending_reads", 64'(exp_q.size() + exp_b_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset_n = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        b_address = '0; b_read = 1'b0; b_write = 1'b0; b_writedata = '0;
        pio_in = '0; b_pio_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pio_out", 64'(pio_out), 64'h0);
        check("rst_irq", 64'(irq), 64'h0);
        check("rst_rdvalid", 64'(avs_readdatavalid), 64'h0);
        check("rst_rdata", 64'(avs_readdata), 64'h0);
        check("rst_b_pio_out", 64'(b_pio_out), 64'h0);
        reset_n = 1'b1;
        tick();

        // output register path
        bus_write(2, REG_DATA, 32'h0000_00A5);
        check("pio_out_ch2", 64'(pio_out[23:16]), 64'hA5);
        bus_read(2, REG_SET, 32'h0000_00A5, "rd_ch2_set");
        bus_write(1, REG_DATA, 32'hFFFF_FF5A);
        bus_read(1, REG_SET, 32'h0000_005A, "rd_ch1_upper_ignored");
        bus_write(2, REG_SET, 32'h0000_000A);
        bus_read(2, REG_SET, 32'h0000_00AF, "rd_ch2_or_set");
        check("pio_out_all", 64'(pio_out), 64'h00AF_5A00);
        bus_rw(2, REG_SET, 32'h0000_0050, 32'h0000_00AF, "rw_pre_write");
        bus_read(2, REG_SET, 32'h0000_00FF, "rw_post_write");
        bus_write(3, REG_MASK, 32'h0000_0080);
        bus_read(3, REG_MASK, 32'h0000_0080, "rd_ch3_mask");
        drain();
        repeat (2) tick();
        check("rdata_hold", 64'(avs_readdata), 64'h80);

        // debounce latency: stable at edge 6 after the input change
        pio_in[7:0] = 8'h01;
        repeat (5) tick();
        bus_read(0, REG_DATA, 32'h0, "ch0_data_cycle5");
        bus_read(0, REG_DATA, 32'h1, "ch0_data_cycle6");
        bus_read(0, REG_EDGE, 32'h1, "ch0_edge_rise");
        repeat (3) tick();
        bus_read(0, REG_DATA, 32'h1, "ch0_data_held");
        check("irq_masked_off", 64'(irq), 64'h0);
        bus_write(0, REG_EDGE, 32'h0);
        bus_read(0, REG_EDGE, 32'h1, "w0_no_clear");
        bus_write(0, REG_EDGE, 32'h1);
        bus_read(0, REG_EDGE, 32'h0, "w1c_clear");

        // glitch shorter than the debounce window
        pio_in[8] = 1'b1;
        repeat (3) tick();
        pio_in[8] = 1'b0;
        repeat (10) tick();
        bus_read(1, REG_DATA, 32'h0, "glitch_data");
        bus_read(1, REG_EDGE, 32'h0, "glitch_edge");
        drain();

        // interrupt timing on ch3 bit 7
        pio_in[31] = 1'b1;
        repeat (7) tick();
        check("irq_before_capture", 64'(irq), 64'h0);
        tick();
        check("irq_set", 64'(irq), 64'h1);
        bus_write(3, REG_EDGE, 32'h0000_0080);
        check("irq_hold_after_w1c", 64'(irq), 64'h1);
        tick();
        check("irq_clear", 64'(irq), 64'h0);
        bus_read(3, REG_EDGE, 32'h0, "ch3_edge_cleared");

        // falling edge ignored in rising mode; capture beats W1C
        pio_in[0] = 1'b0;
        repeat (10) tick();
        bus_read(0, REG_EDGE, 32'h0, "fall_ignored");
        pio_in[0] = 1'b1;
        repeat (6) tick();
        bus_write(0, REG_EDGE, 32'h1);
        bus_read(0, REG_EDGE, 32'h1, "capture_wins");

        // out-of-range channel on the 5-channel instance
        b_bus_read(5, REG_DATA, 32'h0, "b_ch5_read_zero");
        b_bus_write(5, REG_DATA, 32'hFF);
        check("b_ch5_write_ignored", 64'(b_pio_out), 64'h0);
        b_bus_write(4, REG_DATA, 32'h3C);
        b_bus_read(4, REG_SET, 32'h3C, "b_ch4_set");
        check("b_pio_out_ch4", 64'(b_pio_out), 64'h3C_0000_0000);
        drain();

        // reset mid-debounce and mid-read
        bus_write(0, REG_DATA, 32'hFF);
        check("pio_out_ch0_ff", 64'(pio_out[7:0]), 64'hFF);
        bus_write(0, REG_MASK, 32'h1);
        tick();
        check("irq_pre_reset", 64'(irq), 64'h1);
        drain();
        pio_in[16] = 1'b1;
        repeat (2) tick();
        avs_address = 4'(0 * 4 + int'(REG_DATA));
        avs_read    = 1'b1;
        pio_in      = '0;
        reset_n     = 1'b0;
        #1;
        check("async_pio_out", 64'(pio_out), 64'h0);
        check("async_irq", 64'(irq), 64'h0);
        check("async_rdvalid", 64'(avs_readdatavalid), 64'h0);
        tick();
        avs_read = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("no_valid_after_abort", 64'(avs_readdatavalid), 64'h0);
        repeat (12) tick();
        check("post_reset_irq", 64'(irq), 64'h0);
        bus_read(0, REG_EDGE, 32'h0, "post_reset_edge0");
        bus_read(2, REG_EDGE, 32'h0, "post_reset_edge2");
        bus_read(3, REG_EDGE, 32'h0, "post_reset_edge3");
        bus_read(2, REG_DATA, 32'h0, "post_reset_data2");
        drain();

        // release with an input already high
        reset_n   = 1'b0;
        pio_in[0] = 1'b1;
        repeat (2) tick();
        reset_n   = 1'b1;
        bus_read(0, REG_EDGE, 32'h0, "no_edge_at_release");
        bus_read(0, REG_DATA, 32'h0, "data_low_at_release");
        repeat (8) tick();
        bus_read(0, REG_EDGE, 32'h1, "edge_after_debounce");
        bus_read(0, REG_DATA, 32'h1, "data_after_debounce");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
